// File: rtl/lsu_pkg.sv
// Shared decode for the load/store unit: RISC-V funct3 widths, FSM states and
// helpers that turn funct3 into an access size and a legality flag.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} lsu_state_e;

  // Access size in bytes (1, 2 or 4); 0 marks an encoding with no load meaning.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = 3'd1;
      F3_H, F3_HU: f3_size = 3'd2;
      F3_W:        f3_size = 3'd4;
      default:     f3_size = 3'd0;
    endcase
  endfunction

  // Stores have no unsigned variants, so BU/HU are only legal on loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic wr);
    if (wr) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_legal = (f3_size(f3) != 3'd0);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath of the load/store unit: store shift/mask/merge and
// load extract/extend. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] st_shift_o,
  output logic [7:0]  st_mask_o,
  input  logic [3:0]  mrg_mask_i,
  input  logic [31:0] mrg_data_i,
  input  logic [31:0] mrg_word_i,
  output logic [31:0] mrg_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_split_i,
  input  logic [31:0] ld_lo_i,
  input  logic [31:0] ld_hi_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  base_mask;
  logic [31:0] lane_mask;
  logic [63:0] ld_cat;
  logic [31:0] ld_sh;

  always_comb begin
    base_mask = 8'h0F;
    if (size_i == 3'd1)      base_mask = 8'h01;
    else if (size_i == 3'd2) base_mask = 8'h03;
  end

  assign st_shift_o = {32'b0, wdata_i} << {off_i, 3'b000};
  assign st_mask_o  = base_mask << off_i;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane_mask[8*k +: 8] = {8{mrg_mask_i[k]}};
  end

  assign mrg_o = (mrg_word_i & ~lane_mask) | (mrg_data_i & lane_mask);

  // Upper word contributes only when the access actually straddles two words.
  assign ld_cat = {ld_split_i ? ld_hi_i : 32'b0, ld_lo_i};
  assign ld_sh  = 32'(ld_cat >> {ld_off_i, 3'b000});

  always_comb begin
    ld_data_o = ld_sh;
    case (ld_f3_i[1:0])
      2'b00:   ld_data_o = {{24{ld_sh[7]  & ~ld_f3_i[2]}}, ld_sh[7:0]};
      2'b01:   ld_data_o = {{16{ld_sh[15] & ~ld_f3_i[2]}}, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-wide single-port RAM
// with combinational read and synchronous write; splits word-crossing accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int address_width = 1024,
  parameter int data_width    = 32
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [2:0]                       funct3,
  input  logic [31:0]                      addr,
  input  logic [data_width-1:0]            wdata,
  output logic                             resp_valid,
  output logic [data_width-1:0]            rdata,
  output logic                             error,
  output logic                             MemWrite,
  output logic [$clog2(address_width)-1:0] ram_address,
  output logic [data_width-1:0]            ram_write_data,
  input  logic [data_width-1:0]            ram_read_data
);

  localparam int          AW    = $clog2(address_width);
  localparam logic [31:0] DEPTH = 32'(address_width);

  lsu_state_e    state_q, state_d;
  logic          resp_q, resp_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] ahi_q, ahi_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic          wr_q, wr_d;
  logic [3:0]    mk_q, mk_d;
  logic [31:0]   shd_q, shd_d, wlo_q, wlo_d;

  logic [2:0]  size;
  logic [31:0] a_ext, a_p1;
  logic        legal, split, bad, in_second, accept;
  logic [63:0] st_shift;
  logic [7:0]  st_mask;
  logic [31:0] mrg, ld_data;

  assign size      = f3_size(funct3);
  assign legal     = f3_legal(funct3, req_write);
  assign a_ext     = {2'b00, addr[31:2]};
  assign a_p1      = a_ext + 32'd1;
  assign split     = ({1'b0, addr[1:0]} + size) > 3'd4;
  // No wrap: a split touching past the last word is rejected outright.
  assign bad       = !legal || (a_ext >= DEPTH) || (split && (a_p1 >= DEPTH));
  assign in_second = (state_q == SECOND);
  assign accept    = !in_second && req_valid;

  lsu_align u_align (
    .off_i      (addr[1:0]),
    .size_i     (size),
    .wdata_i    (wdata),
    .st_shift_o (st_shift),
    .st_mask_o  (st_mask),
    .mrg_mask_i (in_second ? mk_q  : st_mask[3:0]),
    .mrg_data_i (in_second ? shd_q : st_shift[31:0]),
    .mrg_word_i (ram_read_data),
    .mrg_o      (mrg),
    .ld_f3_i    (in_second ? f3_q  : funct3),
    .ld_off_i   (in_second ? off_q : addr[1:0]),
    .ld_split_i (in_second),
    .ld_lo_i    (in_second ? wlo_q : ram_read_data),
    .ld_hi_i    (ram_read_data),
    .ld_data_o  (ld_data)
  );

  assign req_ready      = !in_second;
  assign ram_address    = in_second ? ahi_q : addr[AW+1:2];
  assign ram_write_data = mrg;
  assign MemWrite       = !RST && (accept ? (req_write && !bad) : (in_second && wr_q));
  assign resp_valid     = resp_q;
  assign rdata          = rdata_q;
  assign error          = err_q;

  always_comb begin
    state_d = state_q;
    resp_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    ahi_d   = ahi_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    mk_d    = mk_q;
    shd_d   = shd_q;
    wlo_d   = wlo_q;
    if (in_second) begin
      state_d = IDLE;
      resp_d  = 1'b1;
      err_d   = 1'b0;
      rdata_d = wr_q ? 32'b0 : ld_data;
    end else if (req_valid) begin
      if (!bad && split) begin
        state_d = SECOND;
        ahi_d   = a_p1[AW-1:0];
        off_d   = addr[1:0];
        f3_d    = funct3;
        wr_d    = req_write;
        mk_d    = st_mask[7:4];
        shd_d   = st_shift[63:32];
        wlo_d   = ram_read_data;
      end else begin
        resp_d  = 1'b1;
        err_d   = bad;
        rdata_d = (bad || req_write) ? 32'b0 : ld_data;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'b0;
      ahi_q   <= '0;
      off_q   <= 2'b0;
      f3_q    <= 3'b0;
      wr_q    <= 1'b0;
      mk_q    <= 4'b0;
      shd_q   <= 32'b0;
      wlo_q   <= 32'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ahi_q   <= ahi_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      mk_q    <= mk_d;
      shd_q   <= shd_d;
      wlo_q   <= wlo_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural single-port RAM
// (combinational read, synchronous write) and hand-computed expectations.
module tb_load_store_unit;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]    funct3 = 3'b0;
  logic [31:0]   addr = 32'b0, wdata = 32'b0;
  logic          req_ready, resp_valid, error, MemWrite;
  logic [31:0]   rdata, ram_write_data, ram_read_data;
  logic [AW-1:0] ram_address;

  logic [31:0]   mem [0:DEPTH-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [31:0]   pl_d = 32'b0;
  int            wr_cnt = 0;
  int            checks = 0, errors = 0;
  int            w0;

  load_store_unit #(.address_width(DEPTH), .data_width(32)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .error(error), .MemWrite(MemWrite),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data)
  );

  always #5 CLK = ~CLK;

  assign ram_read_data = mem[ram_address];

  always @(posedge CLK) begin
    if (MemWrite) begin
      mem[ram_address] <= ram_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (pl_en) mem[pl_a] <= pl_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge CLK);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    step();
    pl_en = 1'b0;
  endtask

  // Presents one request for a single accepting edge; returns 1ns into cycle N+1.
  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge CLK);
    req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    // Reset state, and MemWrite held low while RST is asserted.
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'h0; wdata = 32'hFFFF_FFFF;
    #2;
    chk1("rst_memwrite", MemWrite, 1'b0);
    chk1("rst_resp", resp_valid, 1'b0);
    chk ("rst_rdata", rdata, 32'h0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_ready", req_ready, 1'b1);
    req_valid = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    // SW then LW, aligned, response at N+1.
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    chk1("sw_resp", resp_valid, 1'b1);
    chk ("sw_rdata", rdata, 32'h0);
    chk ("sw_mem4", mem[4], 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk1("lw_resp", resp_valid, 1'b1);
    chk ("lw_rdata", rdata, 32'hDEAD_BEEF);
    chk1("lw_err", error, 1'b0);
    step();
    chk1("lw_pulse", resp_valid, 1'b0);

    // Byte store into lane 3, then signed/unsigned byte loads.
    preload(10'd4, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h13, 32'h0000_0080);
    chk ("sb_mem4", mem[4], 32'h8022_3344);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    chk ("lb_rdata", rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    chk ("lbu_rdata", rdata, 32'h0000_0080);

    // Split LW across words 8/9.
    preload(10'd8, 32'h4433_2211);
    preload(10'd9, 32'h8877_6655);
    issue(1'b0, 3'b010, 32'h22, 32'h0);
    chk1("slw_ready_n1", req_ready, 1'b0);
    chk1("slw_resp_n1", resp_valid, 1'b0);
    step();
    chk1("slw_resp_n2", resp_valid, 1'b1);
    chk ("slw_rdata", rdata, 32'h6655_4433);
    chk1("slw_ready_n2", req_ready, 1'b1);

    // Split SH at offset 3 over zeroed words, then read it back both ways.
    preload(10'd9, 32'h0);
    preload(10'd10, 32'h0);
    issue(1'b1, 3'b001, 32'h27, 32'h0000_BBAA);
    step();
    chk1("ssh_resp", resp_valid, 1'b1);
    chk ("ssh_mem9", mem[9], 32'hAA00_0000);
    chk ("ssh_mem10", mem[10], 32'h0000_00BB);
    issue(1'b0, 3'b001, 32'h27, 32'h0);
    step();
    chk ("slh_rdata", rdata, 32'hFFFF_BBAA);
    issue(1'b0, 3'b101, 32'h27, 32'h0);
    step();
    chk ("slhu_rdata", rdata, 32'h0000_BBAA);

    // Last word is in range; accesses at or beyond the end are errors.
    issue(1'b1, 3'b010, 32'hFFC, 32'h1234_5678);
    chk1("last_sw_err", error, 1'b0);
    chk ("last_mem", mem[1023], 32'h1234_5678);
    issue(1'b0, 3'b010, 32'hFFC, 32'h0);
    chk ("last_lw", rdata, 32'h1234_5678);
    w0 = wr_cnt;
    issue(1'b0, 3'b010, 32'h1000, 32'h0);
    chk1("e1000_resp", resp_valid, 1'b1);
    chk1("e1000_err", error, 1'b1);
    chk ("e1000_rdata", rdata, 32'h0);
    issue(1'b0, 3'b010, 32'hFFD, 32'h0);
    chk1("effd_err", error, 1'b1);
    chk ("effd_rdata", rdata, 32'h0);
    chk1("effd_ready", req_ready, 1'b1);
    issue(1'b0, 3'b011, 32'h0, 32'h0);
    chk1("ef3_err", error, 1'b1);
    issue(1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF);
    chk1("esbu_err", error, 1'b1);
    issue(1'b1, 3'b010, 32'h1000, 32'hFFFF_FFFF);
    chk1("esw_err", error, 1'b1);
    issue(1'b1, 3'b001, 32'hFFF, 32'hFFFF);
    chk1("esh_err", error, 1'b1);
    chk ("err_no_writes", wr_cnt, w0);
    chk ("err_last_mem", mem[1023], 32'h1234_5678);

    // Reset during the second half of a split store.
    preload(10'd8, 32'h4433_2211);
    preload(10'd9, 32'h8877_6655);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    chk ("pre_rst_lw", rdata, 32'h4433_2211);
    issue(1'b1, 3'b010, 32'h22, 32'hCAFE_F00D);
    chk1("rsec_ready", req_ready, 1'b0);
    chk ("rsec_mem8", mem[8], 32'hF00D_2211);
    RST = 1'b1;
    #1;
    chk1("rsec_memwrite", MemWrite, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    step();
    chk ("rsec_mem9", mem[9], 32'h8877_6655);
    chk ("rsec_mem8_kept", mem[8], 32'hF00D_2211);
    chk1("rsec_resp", resp_valid, 1'b0);
    chk ("rsec_rdata", rdata, 32'h0);
    chk1("rsec_error", error, 1'b0);
    chk1("rsec_ready_after", req_ready, 1'b1);

    // Back-to-back byte loads, one per cycle.
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b100; addr = 32'h20;
    step();
    addr = 32'h21;
    chk1("b2b_resp0", resp_valid, 1'b1);
    chk ("b2b_rdata0", rdata, 32'h0000_0011);
    step();
    req_valid = 1'b0;
    chk1("b2b_resp1", resp_valid, 1'b1);
    chk ("b2b_rdata1", rdata, 32'h0000_0022);
    issue(1'b0, 3'b001, 32'h22, 32'h0);
    chk ("lh_neg", rdata, 32'hFFFF_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
